// File: rtl/data_memory_dumper_if.sv
// Debug-dump bus between the data memory dumper, the memory debug port and
// the byte transmitter.
//   i_start / i_abort   : dump command pulses from the debug unit
//   i_debug_read        : word read back at o_debug_pointer
//   i_tx_done           : transmitter finished the current byte
//   o_debug_pointer     : word index driven to the memory debug port
//   o_tx_data/o_tx_start: byte and 1-cycle start pulse to the transmitter
//   o_busy / o_done     : sweep in progress / sweep-complete pulse
// master = dumper side, slave = memory/transmitter/debug-unit side.
interface data_memory_dumper_if #(
   parameter int NUM_DIREC = 7,
   parameter int TAM_DATA  = 32
);
   logic                 i_start;
   logic                 i_abort;
   logic [TAM_DATA-1:0]  i_debug_read;
   logic                 i_tx_done;
   logic [NUM_DIREC-1:0] o_debug_pointer;
   logic [7:0]           o_tx_data;
   logic                 o_tx_start;
   logic                 o_busy;
   logic                 o_done;

   modport master (
      input  i_start, i_abort, i_debug_read, i_tx_done,
      output o_debug_pointer, o_tx_data, o_tx_start, o_busy, o_done
   );

   modport slave (
      output i_start, i_abort, i_debug_read, i_tx_done,
      input  o_debug_pointer, o_tx_data, o_tx_start, o_busy, o_done
   );
endinterface

// File: rtl/data_memory_dumper.sv
// Data memory dumper: on i_start sweeps the debug pointer over words
// 0..NUM_WORDS-1, captures each debug read word and streams it MSB first,
// one byte per transmitter handshake.
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous, active-high reset
//   io_dump  : dump bus (master side), see data_memory_dumper_if
module data_memory_dumper #(
   parameter int NUM_DIREC = 7,
   parameter int TAM_DATA  = 32,
   parameter int NUM_WORDS = 128
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   data_memory_dumper_if.master io_dump
);
   localparam int NUM_BYTES = TAM_DATA / 8;
   localparam int BCW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [BCW-1:0]       LAST_BYTE = BCW'(NUM_BYTES - 1);
   localparam logic [NUM_DIREC-1:0] LAST_WORD = NUM_DIREC'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SET_ADDR, S_LATCH, S_SEND, S_WAIT_TX, S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [NUM_DIREC-1:0] r_word_cnt;
   logic [NUM_DIREC-1:0] r_debug_pointer;
   logic [BCW-1:0]       r_byte_cnt;
   logic [TAM_DATA-1:0]  r_shift;
   logic                 r_tx_start;
   logic                 r_busy;
   logic                 r_done;
   logic                 w_clr_word;
   logic                 w_load_ptr;
   logic                 w_latch;
   logic                 w_shift;
   logic                 w_next_word;

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic; abort overrides everything, including a start in IDLE
   always_comb begin
      w_next = r_state;
      if (io_dump.i_abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:     if (io_dump.i_start) w_next = S_SET_ADDR;
            S_SET_ADDR: w_next = S_LATCH;
            S_LATCH:    w_next = S_SEND;
            S_SEND:     w_next = S_WAIT_TX;
            S_WAIT_TX: begin
               if (io_dump.i_tx_done) begin
                  if (r_byte_cnt < LAST_BYTE)      w_next = S_SEND;
                  else if (r_word_cnt < LAST_WORD) w_next = S_SET_ADDR;
                  else                             w_next = S_DONE;
               end
            end
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
         endcase
      end
   end

   // Datapath strobes decoded from the current state
   always_comb begin
      w_clr_word  = 1'b0;
      w_load_ptr  = 1'b0;
      w_latch     = 1'b0;
      w_shift     = 1'b0;
      w_next_word = 1'b0;
      if (!io_dump.i_abort) begin
         case (r_state)
            S_IDLE:     w_clr_word = io_dump.i_start;
            S_SET_ADDR: w_load_ptr = 1'b1;
            S_LATCH:    w_latch    = 1'b1;
            S_WAIT_TX: begin
               if (io_dump.i_tx_done) begin
                  if (r_byte_cnt < LAST_BYTE)      w_shift     = 1'b1;
                  else if (r_word_cnt < LAST_WORD) w_next_word = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Pulses and busy are registered from the next state so that each is
   // high exactly while the FSM sits in SEND / DONE / non-IDLE.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_tx_start      <= 1'b0;
         r_done          <= 1'b0;
         r_busy          <= 1'b0;
         r_word_cnt      <= '0;
         r_debug_pointer <= '0;
         r_byte_cnt      <= '0;
         r_shift         <= '0;
      end else begin
         r_tx_start <= (w_next == S_SEND);
         r_done     <= (w_next == S_DONE);
         r_busy     <= (w_next != S_IDLE);
         if (w_clr_word)       r_word_cnt <= '0;
         else if (w_next_word) r_word_cnt <= r_word_cnt + NUM_DIREC'(1);
         if (w_load_ptr) r_debug_pointer <= r_word_cnt;
         if (w_latch) begin
            r_shift    <= io_dump.i_debug_read;
            r_byte_cnt <= '0;
         end else if (w_shift) begin
            r_shift    <= r_shift << 8;
            r_byte_cnt <= r_byte_cnt + BCW'(1);
         end
      end
   end

   // Top byte of the shift register is stable through SEND and WAIT_TX
   assign io_dump.o_tx_data       = r_shift[TAM_DATA-1 -: 8];
   assign io_dump.o_tx_start      = r_tx_start;
   assign io_dump.o_busy          = r_busy;
   assign io_dump.o_done          = r_done;
   assign io_dump.o_debug_pointer = r_debug_pointer;
endmodule

// File: tb/tb_data_memory_dumper.sv
// Testbench for data_memory_dumper: a 2-word instance (dut_a) for handshake
// corner cases and a default 128-word instance (dut_b) for full sweeps.
// Each sweep is checked against the byte stream computed from the memory
// image: word w, byte b (MSB first) = mem[w] >> 8*(3-b), pointer = w.
module tb_data_memory_dumper;
   localparam int LOGSZ = 2048;

   logic        clk;
   logic        rst;
   logic [1:0]  st, ab, inj, autod;
   logic [31:0] mem [2][128];
   int          dly [2];
   int unsigned cyc;
   int          n_tests, n_fail;

   // Observed stream, written only by the monitor process
   logic [7:0]  byte_log [2][LOGSZ];
   logic [6:0]  ptr_log  [2][LOGSZ];
   int unsigned cyc_log  [2][LOGSZ];
   int          nbytes [2], ndone [2], b2b [2], hold_err [2], cnt [2];
   logic [7:0]  last_b [2];
   logic        prev_s [2], prev_d [2];

   logic        txs_w [2], busy_w [2], done_w [2];
   logic [7:0]  txd_w [2];
   logic [6:0]  ptr_w [2];

   data_memory_dumper_if #(.NUM_DIREC(7), .TAM_DATA(32)) bus_a ();
   data_memory_dumper_if #(.NUM_DIREC(7), .TAM_DATA(32)) bus_b ();

   assign bus_a.i_start      = st[0];
   assign bus_a.i_abort      = ab[0];
   assign bus_a.i_tx_done    = autod[0] | inj[0];
   assign bus_a.i_debug_read = mem[0][bus_a.o_debug_pointer];
   assign bus_b.i_start      = st[1];
   assign bus_b.i_abort      = ab[1];
   assign bus_b.i_tx_done    = autod[1] | inj[1];
   assign bus_b.i_debug_read = mem[1][bus_b.o_debug_pointer];

   assign txs_w[0]  = bus_a.o_tx_start;
   assign txs_w[1]  = bus_b.o_tx_start;
   assign busy_w[0] = bus_a.o_busy;
   assign busy_w[1] = bus_b.o_busy;
   assign done_w[0] = bus_a.o_done;
   assign done_w[1] = bus_b.o_done;
   assign txd_w[0]  = bus_a.o_tx_data;
   assign txd_w[1]  = bus_b.o_tx_data;
   assign ptr_w[0]  = bus_a.o_debug_pointer;
   assign ptr_w[1]  = bus_b.o_debug_pointer;

   data_memory_dumper #(.NUM_DIREC(7), .TAM_DATA(32), .NUM_WORDS(2)) dut_a (
      .i_clk(clk), .i_reset(rst), .io_dump(bus_a)
   );
   data_memory_dumper #(.NUM_DIREC(7), .TAM_DATA(32), .NUM_WORDS(128)) dut_b (
      .i_clk(clk), .i_reset(rst), .io_dump(bus_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Transmitter model + monitor: logs every started byte, answers it with
   // a done pulse after dly cycles (dly=0 -> random 1..6), and tracks
   // back-to-back pulses and tx_data stability while a byte is in flight.
   initial begin
      autod = '0;
      for (int d = 0; d < 2; d++) begin
         nbytes[d] = 0; ndone[d] = 0; b2b[d] = 0; hold_err[d] = 0; cnt[d] = 0;
         last_b[d] = '0; prev_s[d] = 1'b0; prev_d[d] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            autod[d] = 1'b0;
            if (rst) begin
               cnt[d] = 0; prev_s[d] = 1'b0; prev_d[d] = 1'b0;
            end else begin
               if (cnt[d] > 0) begin
                  cnt[d]--;
                  if (cnt[d] == 0) begin
                     autod[d] = 1'b1;
                     if (txd_w[d] !== last_b[d]) hold_err[d]++;
                  end
               end
               if (txs_w[d]) begin
                  if (nbytes[d] < LOGSZ) begin
                     byte_log[d][nbytes[d]] = txd_w[d];
                     ptr_log[d][nbytes[d]]  = ptr_w[d];
                     cyc_log[d][nbytes[d]]  = cyc;
                  end
                  nbytes[d]++;
                  last_b[d] = txd_w[d];
                  cnt[d] = (dly[d] > 0) ? dly[d] : int'($urandom_range(6, 1));
                  if (prev_s[d]) b2b[d]++;
               end
               if (done_w[d]) begin
                  ndone[d]++;
                  if (prev_d[d]) b2b[d]++;
               end
               prev_s[d] = txs_w[d];
               prev_d[d] = done_w[d];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input int d, input string tag);
      chk({tag, "_busy"},  32'(busy_w[d]), 32'd0);
      chk({tag, "_start"}, 32'(txs_w[d]),  32'd0);
      chk({tag, "_done"},  32'(done_w[d]), 32'd0);
      chk({tag, "_ptr"},   32'(ptr_w[d]),  32'd0);
      chk({tag, "_data"},  32'(txd_w[d]),  32'd0);
   endtask

   task automatic start_pulse(input int d, output int unsigned t0);
      @(negedge clk);
      st[d] = 1'b1;
      t0 = cyc;
      @(negedge clk);
      st[d] = 1'b0;
   endtask

   task automatic wait_done(input int d, input int d0);
      int k;
      k = 0;
      while (ndone[d] == d0 && k < 8000) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic check_sweep(input int d, input int nw, input int b0, input int d0,
                              input int unsigned t0, input string tag);
      logic [31:0] w;
      logic [7:0]  eb;
      repeat (3) @(negedge clk);
      chk({tag, "_ndone"}, 32'(ndone[d] - d0), 32'd1);
      chk({tag, "_busy_after"}, 32'(busy_w[d]), 32'd0);
      chk({tag, "_done_after"}, 32'(done_w[d]), 32'd0);
      chk({tag, "_nbytes"}, 32'(nbytes[d] - b0), 32'(nw * 4));
      chk({tag, "_latency"}, 32'(cyc_log[d][b0] - t0), 32'd3);
      for (int j = 0; j < nw * 4 && b0 + j < LOGSZ; j++) begin
         w  = mem[d][j / 4];
         eb = 8'(w >> (8 * (3 - (j % 4))));
         chk({tag, "_byte"}, 32'(byte_log[d][b0 + j]), 32'(eb));
         chk({tag, "_ptr"},  32'(ptr_log[d][b0 + j]),  32'(j / 4));
      end
   endtask

   initial begin
      int          b0, d0, k;
      int unsigned t0;
      n_tests = 0; n_fail = 0;
      st = '0; ab = '0; inj = '0;
      dly[0] = 5; dly[1] = 5;
      for (int i = 0; i < 128; i++) begin
         mem[0][i] = '0;
         mem[1][i] = '0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle(0, "rst_a");
      check_idle(1, "rst_b");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_idle(0, "post_rst_a");

      // Two-word dump, done 5 cycles after each start
      mem[0][0] = 32'hDEADBEEF; mem[0][1] = 32'h01020304; dly[0] = 5;
      b0 = nbytes[0]; d0 = ndone[0];
      start_pulse(0, t0);
      wait_done(0, d0);
      check_sweep(0, 2, b0, d0, t0, "t2");

      // Spurious tx_done in IDLE and in the SEND cycle
      for (int i = 0; i < 2; i++) mem[0][i] = $urandom;
      dly[0] = 4;
      b0 = nbytes[0]; d0 = ndone[0];
      @(negedge clk); inj[0] = 1'b1;
      @(negedge clk); inj[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("t3_idle_busy", 32'(busy_w[0]), 32'd0);
      chk("t3_idle_bytes", 32'(nbytes[0] - b0), 32'd0);
      start_pulse(0, t0);
      @(negedge clk);
      @(negedge clk);
      chk("t3_in_send", 32'(txs_w[0]), 32'd1);
      inj[0] = 1'b1;
      @(negedge clk); inj[0] = 1'b0;
      wait_done(0, d0);
      check_sweep(0, 2, b0, d0, t0, "t3");

      // Repeated start while busy
      mem[0][0] = 32'hDEADBEEF; mem[0][1] = 32'h01020304; dly[0] = 5;
      b0 = nbytes[0]; d0 = ndone[0];
      start_pulse(0, t0);
      k = 0;
      while (ndone[0] == d0 && k < 2000) begin
         @(negedge clk);
         k++;
         st[0] = busy_w[0] && !done_w[0] && (k % 5 == 2);
      end
      st[0] = 1'b0;
      check_sweep(0, 2, b0, d0, t0, "t4");

      // Abort in the WAIT_TX of the third byte
      dly[0] = 6;
      b0 = nbytes[0]; d0 = ndone[0];
      start_pulse(0, t0);
      k = 0;
      while (nbytes[0] < b0 + 3 && k < 500) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk); ab[0] = 1'b1;
      @(negedge clk); ab[0] = 1'b0;
      chk("t5_busy_after_abort", 32'(busy_w[0]), 32'd0);
      repeat (12) @(negedge clk);
      chk("t5_bytes_after_abort", 32'(nbytes[0] - b0), 32'd3);
      chk("t5_no_done", 32'(ndone[0] - d0), 32'd0);
      b0 = nbytes[0];
      @(negedge clk); st[0] = 1'b1; ab[0] = 1'b1;
      @(negedge clk); st[0] = 1'b0; ab[0] = 1'b0;
      chk("t5_abort_start_busy", 32'(busy_w[0]), 32'd0);
      repeat (5) @(negedge clk);
      chk("t5_abort_start_bytes", 32'(nbytes[0] - b0), 32'd0);
      dly[0] = 0;
      b0 = nbytes[0]; d0 = ndone[0];
      start_pulse(0, t0);
      wait_done(0, d0);
      chk("t5_restart_first_byte", 32'(byte_log[0][b0]), 32'h0000_00DE);
      check_sweep(0, 2, b0, d0, t0, "t5r");

      // Reset while waiting on the transmitter (second word in flight)
      for (int i = 0; i < 2; i++) mem[0][i] = $urandom;
      dly[0] = 10;
      b0 = nbytes[0];
      start_pulse(0, t0);
      k = 0;
      while (nbytes[0] < b0 + 5 && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("t1_reached_word1", 32'(nbytes[0] - b0 >= 5), 32'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_idle(0, "t1_rst");
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 2; i++) mem[0][i] = $urandom;
      dly[0] = 0;
      b0 = nbytes[0]; d0 = ndone[0];
      start_pulse(0, t0);
      wait_done(0, d0);
      check_sweep(0, 2, b0, d0, t0, "t1");

      // Full 128-word sweep, mem[k] = k
      for (int i = 0; i < 128; i++) mem[1][i] = 32'(i);
      dly[1] = 0;
      b0 = nbytes[1]; d0 = ndone[1];
      start_pulse(1, t0);
      wait_done(1, d0);
      check_sweep(1, 128, b0, d0, t0, "t6");
      chk("t6_last_b0", 32'(byte_log[1][b0 + 508]), 32'h0000_0000);
      chk("t6_last_b3", 32'(byte_log[1][b0 + 511]), 32'h0000_007F);

      // Full sweep with random contents and the fastest transmitter
      for (int i = 0; i < 128; i++) mem[1][i] = $urandom;
      dly[1] = 1;
      b0 = nbytes[1]; d0 = ndone[1];
      start_pulse(1, t0);
      wait_done(1, d0);
      check_sweep(1, 128, b0, d0, t0, "t6r");

      for (int d = 0; d < 2; d++) begin
         chk("pulse_back_to_back", 32'(b2b[d]), 32'd0);
         chk("tx_data_hold", 32'(hold_err[d]), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
